// File: rtl/pipe_execute_stage.sv
// Y86 execute stage: operand select, ALU with optional shifts, gated condition codes,
// cond/cmov evaluation and the E->M pipeline register.
module pipe_execute_stage #(
    parameter int          WIDTH    = 64,
    parameter int          EXT_OPS  = 1,
    parameter logic [3:0]  RNONE    = 4'hF,
    parameter logic [2:0]  CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    input  logic             M_bubble,
    output logic [WIDTH-1:0] e_valE,
    output logic             e_cnd,
    output logic [3:0]       e_dstE,
    output logic [2:0]       cc_out,
    output logic [2:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    localparam int               MSB    = WIDTH - 1;
    localparam int               SHW    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] C_STEP = WIDTH'(WIDTH / 8);

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;
    logic [3:0]       w_alufun;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_of;
    logic [2:0]       w_flags;
    logic             w_set_cc;
    logic             w_zf;
    logic             w_sf;
    logic             w_ovf;

    logic [2:0]       r_cc;
    logic [2:0]       r_m_stat;
    logic [3:0]       r_m_icode;
    logic             r_m_cnd;
    logic [WIDTH-1:0] r_m_vale;
    logic [WIDTH-1:0] r_m_vala;
    logic [3:0]       r_m_dste;
    logic [3:0]       r_m_dstm;

    always_comb begin
        w_alu_a = '0;
        case (E_icode)
            4'h2, 4'h6:       w_alu_a = E_valA;
            4'h3, 4'h4, 4'h5: w_alu_a = E_valC;
            4'h8, 4'hA:       w_alu_a = -C_STEP;
            4'h9, 4'hB:       w_alu_a = C_STEP;
            default:          w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alu_b = E_valB;
            default:                                  w_alu_b = '0;
        endcase
    end

    assign w_alufun = (E_icode == 4'h6) ? E_ifun : 4'h0;
    assign w_sum    = w_alu_b + w_alu_a;
    assign w_diff   = w_alu_b - w_alu_a;

    // Any function code without a dedicated operation falls back to add, flags included.
    always_comb begin
        w_res = w_sum;
        w_of  = (w_alu_a[MSB] == w_alu_b[MSB]) && (w_sum[MSB] != w_alu_b[MSB]);
        case (w_alufun)
            4'h1: begin
                w_res = w_diff;
                w_of  = (w_alu_a[MSB] != w_alu_b[MSB]) && (w_diff[MSB] != w_alu_b[MSB]);
            end
            4'h2: begin
                w_res = w_alu_b & w_alu_a;
                w_of  = 1'b0;
            end
            4'h3: begin
                w_res = w_alu_b ^ w_alu_a;
                w_of  = 1'b0;
            end
            4'h4: begin
                if (EXT_OPS != 0) begin
                    w_res = w_alu_b << w_alu_a[SHW-1:0];
                    w_of  = 1'b0;
                end
            end
            4'h5: begin
                if (EXT_OPS != 0) begin
                    w_res = $signed(w_alu_b) >>> w_alu_a[SHW-1:0];
                    w_of  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign w_flags  = {(w_res == '0), w_res[MSB], w_of};
    assign w_set_cc = (E_icode == 4'h6) && (E_stat == SAOK)
                   && !(m_stat == SADR || m_stat == SINS || m_stat == SHLT)
                   && !(W_stat == SADR || W_stat == SINS || W_stat == SHLT);

    // Conditions read the registered flags, not the ones being computed this cycle.
    assign w_zf  = r_cc[2];
    assign w_sf  = r_cc[1];
    assign w_ovf = r_cc[0];

    always_comb begin
        e_cnd = 1'b0;
        case (E_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = (w_sf ^ w_ovf) | w_zf;
            4'h2:    e_cnd = w_sf ^ w_ovf;
            4'h3:    e_cnd = w_zf;
            4'h4:    e_cnd = !w_zf;
            4'h5:    e_cnd = !(w_sf ^ w_ovf);
            4'h6:    e_cnd = !(w_sf ^ w_ovf) && !w_zf;
            default: e_cnd = 1'b0;
        endcase
    end

    assign e_valE = w_res;
    assign e_dstE = (E_icode == 4'h2 && !e_cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_set_cc) begin
            r_cc <= w_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble) begin
            r_m_stat  <= SBUB;
            r_m_icode <= 4'h1;
            r_m_cnd   <= 1'b0;
            r_m_vale  <= '0;
            r_m_vala  <= '0;
            r_m_dste  <= RNONE;
            r_m_dstm  <= RNONE;
        end else begin
            r_m_stat  <= E_stat;
            r_m_icode <= E_icode;
            r_m_cnd   <= e_cnd;
            r_m_vale  <= w_res;
            r_m_vala  <= E_valA;
            r_m_dste  <= e_dstE;
            r_m_dstm  <= E_dstM;
        end
    end

    assign cc_out  = r_cc;
    assign M_stat  = r_m_stat;
    assign M_icode = r_m_icode;
    assign M_cnd   = r_m_cnd;
    assign M_valE  = r_m_vale;
    assign M_valA  = r_m_vala;
    assign M_dstE  = r_m_dste;
    assign M_dstM  = r_m_dstm;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Directed-vector bench for pipe_execute_stage (64-bit instance plus a 32-bit instance).
module tb_pipe_execute_stage;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;

    logic        clk;
    logic        rst;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic        M_bubble;
    logic [63:0] e_valE;
    logic        e_cnd;
    logic [3:0]  e_dstE;
    logic [2:0]  cc_out;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    logic [3:0]  n_icode;
    logic [31:0] n_valB;
    logic [31:0] n_zero;
    logic [31:0] n_valE;
    logic        n_cnd;
    logic [3:0]  n_dstE;
    logic [2:0]  n_cc;
    logic [2:0]  n_m_stat;
    logic [3:0]  n_m_icode;
    logic        n_m_cnd;
    logic [31:0] n_m_valE;
    logic [31:0] n_m_valA;
    logic [3:0]  n_m_dstE;
    logic [3:0]  n_m_dstM;

    int n_cmp;
    int n_err;

    pipe_execute_stage #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_cnd(e_cnd), .e_dstE(e_dstE), .cc_out(cc_out),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    pipe_execute_stage #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .E_stat(SAOK), .E_icode(n_icode), .E_ifun(4'h0),
        .E_valC(n_zero), .E_valA(n_zero), .E_valB(n_valB), .E_dstE(4'hF), .E_dstM(4'hF),
        .m_stat(SAOK), .W_stat(SAOK), .M_bubble(1'b0),
        .e_valE(n_valE), .e_cnd(n_cnd), .e_dstE(n_dstE), .cc_out(n_cc),
        .M_stat(n_m_stat), .M_icode(n_m_icode), .M_cnd(n_m_cnd), .M_valE(n_m_valE),
        .M_valA(n_m_valA), .M_dstE(n_m_dstE), .M_dstM(n_m_dstM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] vala, input logic [63:0] valb);
        E_icode = icode;
        E_ifun  = ifun;
        E_valA  = vala;
        E_valB  = valb;
        #1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        E_stat   = SAOK;
        E_icode  = 4'h1;
        E_ifun   = 4'h0;
        E_valC   = 64'h0;
        E_valA   = 64'h0;
        E_valB   = 64'h0;
        E_dstE   = 4'h3;
        E_dstM   = 4'hF;
        m_stat   = SAOK;
        W_stat   = SAOK;
        M_bubble = 1'b0;
        n_icode  = 4'h1;
        n_valB   = 32'h0;
        n_zero   = 32'h0;

        #3;
        check("rst_cc", 64'(cc_out), 64'h4);
        check("rst_m_icode", 64'(M_icode), 64'h1);
        check("rst_m_stat", 64'(M_stat), 64'(SBUB));
        check("rst_m_dstE", 64'(M_dstE), 64'hF);
        check("rst_m_dstM", 64'(M_dstM), 64'hF);
        check("rst_m_valE", M_valE, 64'h0);
        rst = 1'b0;

        // cmovle with ZF=1 from reset: move happens, valE = valA
        drive(4'h2, 4'h1, 64'h5, 64'h99);
        check("cmovle_cnd", 64'(e_cnd), 64'h1);
        check("cmovle_dstE", 64'(e_dstE), 64'h3);
        check("cmovle_valE", e_valE, 64'h5);
        step();
        check("cmovle_m_icode", 64'(M_icode), 64'h2);
        check("cmovle_m_cnd", 64'(M_cnd), 64'h1);
        check("cmovle_m_valE", M_valE, 64'h5);
        check("cmovle_m_valA", M_valA, 64'h5);
        check("cmovle_m_stat", 64'(M_stat), 64'(SAOK));
        check("cc_hold_nonop", 64'(cc_out), 64'h4);

        drive(4'h6, 4'h1, 64'h1, 64'h1);
        check("sub_zero_valE", e_valE, 64'h0);
        step();
        check("sub_zero_cc", 64'(cc_out), 64'h4);

        drive(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF);
        check("add_ovf_valE", e_valE, 64'h8000_0000_0000_0000);
        step();
        check("add_ovf_cc", 64'(cc_out), 64'h3);

        // exception in later stages blocks the CC write but not the M capture
        m_stat = SADR;
        drive(4'h6, 4'h0, 64'h1, 64'h1);
        step();
        check("madr_cc_hold", 64'(cc_out), 64'h3);
        check("madr_m_valE", M_valE, 64'h2);
        m_stat = SAOK;
        W_stat = SHLT;
        drive(4'h6, 4'h0, 64'h3, 64'h4);
        step();
        check("whlt_cc_hold", 64'(cc_out), 64'h3);
        check("whlt_m_valE", M_valE, 64'h7);
        W_stat = SAOK;

        drive(4'h6, 4'h1, 64'h7, 64'h5);
        check("sub_neg_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(4'h6, 4'h1, 64'h1, 64'h1);
        step();
        check("sub_back_cc", 64'(cc_out), 64'h4);

        drive(4'h2, 4'h4, 64'h5, 64'h0);
        check("cmovne_z_cnd", 64'(e_cnd), 64'h0);
        check("cmovne_z_dstE", 64'(e_dstE), 64'hF);
        step();
        check("cmovne_z_m_cnd", 64'(M_cnd), 64'h0);
        check("cmovne_z_m_dstE", 64'(M_dstE), 64'hF);

        drive(4'h6, 4'h0, 64'h1, 64'h1);
        step();
        check("add_small_cc", 64'(cc_out), 64'h0);
        drive(4'h2, 4'h4, 64'h5, 64'h0);
        check("cmovne_nz_cnd", 64'(e_cnd), 64'h1);
        check("cmovne_nz_dstE", 64'(e_dstE), 64'h3);
        drive(4'h7, 4'h2, 64'h0, 64'h0);
        check("jl_cnd", 64'(e_cnd), 64'h0);
        drive(4'h7, 4'h6, 64'h0, 64'h0);
        check("jg_cnd", 64'(e_cnd), 64'h1);
        drive(4'h7, 4'h7, 64'h0, 64'h0);
        check("jbad_cnd", 64'(e_cnd), 64'h0);
        drive(4'h7, 4'h2, 64'h0, 64'h0);
        check("jmp_dstE_kept", 64'(e_dstE), 64'h3);

        drive(4'hA, 4'h0, 64'h0, 64'h100);
        check("pushq_valE", e_valE, 64'hF8);
        drive(4'hB, 4'h0, 64'h0, 64'h100);
        check("popq_valE", e_valE, 64'h108);
        drive(4'h8, 4'h0, 64'h0, 64'h100);
        check("call_valE", e_valE, 64'hF8);
        E_valC = 64'h55;
        drive(4'h3, 4'h0, 64'h0, 64'h100);
        check("irmov_valE", e_valE, 64'h55);
        n_icode = 4'hA;
        n_valB  = 32'h100;
        #1;
        check("pushq32_valE", 64'(n_valE), 64'hFC);

        drive(4'h6, 4'h2, 64'hF0, 64'h3C);
        check("and_valE", e_valE, 64'h30);
        drive(4'h6, 4'h3, 64'hF0, 64'h3C);
        check("xor_valE", e_valE, 64'hCC);
        drive(4'h6, 4'h7, 64'h2, 64'h3);
        check("ifun7_add_valE", e_valE, 64'h5);

        // SAR with a simultaneous bubble: CC updates, M is bubbled
        M_bubble = 1'b1;
        drive(4'h6, 4'h5, 64'h4, 64'h8000_0000_0000_0000);
        check("sar_valE", e_valE, 64'hF800_0000_0000_0000);
        step();
        check("sar_cc", 64'(cc_out), 64'h2);
        check("bub_m_stat", 64'(M_stat), 64'(SBUB));
        check("bub_m_icode", 64'(M_icode), 64'h1);
        check("bub_m_valE", M_valE, 64'h0);
        check("bub_m_dstE", 64'(M_dstE), 64'hF);
        M_bubble = 1'b0;

        E_dstM = 4'h6;
        drive(4'h6, 4'h4, 64'h4, 64'h1);
        check("shl_valE", e_valE, 64'h10);
        step();
        check("shl_cc", 64'(cc_out), 64'h0);
        check("shl_m_icode", 64'(M_icode), 64'h6);
        check("shl_m_valE", M_valE, 64'h10);
        check("shl_m_dstM", 64'(M_dstM), 64'h6);

        // asynchronous reset between edges
        #1;
        rst = 1'b1;
        #1;
        check("arst_cc", 64'(cc_out), 64'h4);
        check("arst_m_icode", 64'(M_icode), 64'h1);
        check("arst_m_stat", 64'(M_stat), 64'(SBUB));
        check("arst_m_valE", M_valE, 64'h0);
        check("arst_m_dstM", 64'(M_dstM), 64'hF);
        #1;
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
